// File: rtl/matrix_scan_capture_pkg.sv
// Shared definitions for the 8x8 matrix scan path: dimensions, frame bit
// mapping and row-strobe helpers used by both the driver and the capture side.
package matrix_scan_capture_pkg;

    localparam int MATRIX_DIM = 8;
    localparam int FRAME_BITS = MATRIX_DIM * MATRIX_DIM;

    // Single source of truth for pixel (r, c) -> frame bit position.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c);
        return MATRIX_DIM * r + c;
    endfunction

    function automatic logic onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] row_of(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < MATRIX_DIM; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_scan_capture_scan_input_filter.sv
// Synchronizes the asynchronous scan bus, normalizes polarity and raises a
// single accept strobe once a {rows, columns} value has been stable long enough.
module scan_input_filter
    import matrix_scan_capture_pkg::*;
#(
    parameter int ROW_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 0,
    parameter int STABLE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rows_in,
    input  logic [7:0] cols_in,
    output logic       accept,
    output logic [7:0] acc_rows,
    output logic [7:0] acc_cols
);

    localparam logic [7:0] ROW_XOR = (ROW_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0] COL_XOR = (COL_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    logic [7:0]  rows_s1_q, rows_s1_d, rows_s2_q, rows_s2_d;
    logic [7:0]  cols_s1_q, cols_s1_d, cols_s2_q, cols_s2_d;
    logic [15:0] prev_q, prev_d;
    logic [7:0]  count_q, count_d;
    logic        fired_q, fired_d;
    logic [15:0] sample;

    always_comb begin
        rows_s1_d = rows_in;
        rows_s2_d = rows_s1_q;
        cols_s1_d = cols_in;
        cols_s2_d = cols_s1_q;
        sample    = {rows_s2_q ^ ROW_XOR, cols_s2_q ^ COL_XOR};
        prev_d    = sample;
        count_d   = count_q;
        fired_d   = fired_q;
        accept    = 1'b0;
        // fired_q latches after an accept so a held value is accepted only once.
        if (sample != prev_q) begin
            count_d = 8'd0;
            fired_d = 1'b0;
        end else if (!fired_q) begin
            if (count_q == LAST_CNT) begin
                accept  = 1'b1;
                fired_d = 1'b1;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
        acc_rows = prev_q[15:8];
        acc_cols = prev_q[7:0];
    end

    // Synchronizers reset to the idle bus level so no phantom row appears after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rows_s1_q <= ROW_XOR;
            rows_s2_q <= ROW_XOR;
            cols_s1_q <= COL_XOR;
            cols_s2_q <= COL_XOR;
            prev_q    <= 16'd0;
            count_q   <= 8'd0;
            fired_q   <= 1'b0;
        end else begin
            rows_s1_q <= rows_s1_d;
            rows_s2_q <= rows_s2_d;
            cols_s1_q <= cols_s1_d;
            cols_s2_q <= cols_s2_d;
            prev_q    <= prev_d;
            count_q   <= count_d;
            fired_q   <= fired_d;
        end
    end

endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds 64-bit frames from a row-strobed scan bus and presents each
// completed frame on a valid/ready interface, with a partial-frame timeout.
module matrix_scan_capture
    import matrix_scan_capture_pkg::*;
#(
    parameter int ROW_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 0,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_n,
    input  logic [7:0]            rows,
    input  logic [7:0]            columns,
    output logic [FRAME_BITS-1:0] o_frame,
    output logic                  o_frame_valid,
    input  logic                  i_frame_ready,
    output logic                  o_locked,
    output logic                  o_err_multirow,
    output logic                  o_overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic                  accept;
    logic [7:0]            acc_rows, acc_cols;
    logic [FRAME_BITS-1:0] buf_q, buf_d, frame_q, frame_d;
    logic [7:0]            seen_q, seen_d, seen_next;
    logic                  valid_q, valid_d, locked_q, locked_d;
    logic                  err_q, err_d, overrun_q, overrun_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [2:0]            row_sel;

    scan_input_filter #(
        .ROW_ACTIVE_LOW(ROW_ACTIVE_LOW),
        .COL_ACTIVE_LOW(COL_ACTIVE_LOW),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk     (i_CLK),
        .rst_n   (i_RST_n),
        .rows_in (rows),
        .cols_in (columns),
        .accept  (accept),
        .acc_rows(acc_rows),
        .acc_cols(acc_cols)
    );

    // Handshake: a frame transfers on every cycle with o_frame_valid & i_frame_ready;
    // o_frame is held while valid, and a new frame may load in the transfer cycle.
    always_comb begin
        buf_d     = buf_q;
        seen_d    = seen_q;
        seen_next = seen_q;
        frame_d   = frame_q;
        valid_d   = valid_q & ~i_frame_ready;
        locked_d  = locked_q;
        err_d     = 1'b0;
        overrun_d = overrun_q;
        tmo_d     = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
        row_sel   = row_of(acc_rows);
        if (tmo_q == TMO_MAX) begin
            seen_d   = 8'd0;
            locked_d = 1'b0;
        end
        // Accept is evaluated after the timeout so a coinciding row write wins.
        if (accept) begin
            if (onehot8(acc_rows)) begin
                buf_d[6'(idx(32'(row_sel), 0)) +: 8] = acc_cols;
                seen_next = seen_q | acc_rows;
                seen_d    = seen_next;
                tmo_d     = '0;
                if (seen_next == 8'hFF) begin
                    seen_d   = 8'd0;
                    locked_d = 1'b1;
                    if (!valid_q || i_frame_ready) begin
                        frame_d = buf_d;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end else if (acc_rows != 8'd0) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            buf_q     <= '0;
            seen_q    <= 8'd0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            buf_q     <= buf_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            tmo_q     <= tmo_d;
        end
    end

    assign o_frame        = frame_q;
    assign o_frame_valid  = valid_q;
    assign o_locked       = locked_q;
    assign o_err_multirow = err_q;
    assign o_overrun      = overrun_q;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Directed bench for matrix_scan_capture: an active-high instance and an
// active-low instance, with a frame scoreboard checked on every transfer.
module tb_matrix_scan_capture;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n, rst1_n;
    logic [7:0]  rows0, cols0, rows1, cols1;
    logic        ready0, ready1;
    logic [63:0] frame0, frame1;
    logic        valid0, valid1, locked0, locked1, err0, err1, ovr0, ovr1;

    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    int          n_vec, n_err, err_pulses0;

    localparam logic [63:0] DIAG  = 64'h8040201008040201;
    localparam logic [63:0] FRM_A = 64'h1716151413121110;
    localparam logic [63:0] ONES  = 64'hFFFFFFFFFFFFFFFF;

    matrix_scan_capture #(
        .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(0), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)
    ) dut0 (
        .i_CLK(clk), .i_RST_n(rst0_n), .rows(rows0), .columns(cols0),
        .o_frame(frame0), .o_frame_valid(valid0), .i_frame_ready(ready0),
        .o_locked(locked0), .o_err_multirow(err0), .o_overrun(ovr0)
    );

    matrix_scan_capture #(
        .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)
    ) dut1 (
        .i_CLK(clk), .i_RST_n(rst1_n), .rows(rows1), .columns(cols1),
        .o_frame(frame1), .o_frame_valid(valid1), .i_frame_ready(ready1),
        .o_locked(locked1), .o_err_multirow(err1), .o_overrun(ovr1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (err0) err_pulses0++;
            if (valid0 && ready0) begin
                if (exp_q0.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frame0_unexpected: got %h, required no transfer", frame0);
                end else begin
                    check("frame0_xfer", frame0, exp_q0.pop_front());
                end
            end
            if (valid1 && ready1) begin
                if (exp_q1.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL frame1_unexpected: got %h, required no transfer", frame1);
                end else begin
                    check("frame1_xfer", frame1, exp_q1.pop_front());
                end
            end
        end
    endtask

    task automatic drive0(input logic [7:0] r, input logic [7:0] c, input int hold);
        rows0 = r;
        cols0 = c;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [7:0] r, input logic [7:0] c, input int hold);
        rows1 = r;
        cols1 = c;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        err_pulses0 = 0;
        rows0 = 8'h00; cols0 = 8'h00; ready0 = 1'b1; rst0_n = 1'b0;
        rows1 = 8'hFF; cols1 = 8'hFF; ready1 = 1'b1; rst1_n = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst0_n = 1'b1;
        rst1_n = 1'b1;

        // reset state
        check("rst_frame", frame0, 64'd0);
        check("rst_valid", 64'(valid0), 64'd0);
        check("rst_locked", 64'(locked0), 64'd0);
        check("rst_overrun", 64'(ovr0), 64'd0);
        check("rst_err", 64'(err0), 64'd0);

        // diagonal frame, consumer always ready
        exp_q0.push_back(DIAG);
        for (int r = 0; r < 8; r++) drive0(8'h01 << r, 8'h01 << r, 20);
        drive0(8'h00, 8'h00, 10);
        check("s1_locked", 64'(locked0), 64'd1);
        check("s1_valid_after_xfer", 64'(valid0), 64'd0);
        check("s1_overrun", 64'(ovr0), 64'd0);

        // held frame A, then frame B arrives while A is unconsumed
        ready0 = 1'b0;
        exp_q0.push_back(FRM_A);
        for (int r = 0; r < 8; r++) drive0(8'h01 << r, 8'(8'h10 + r), 20);
        drive0(8'h00, 8'h00, 10);
        check("s2_valid_held", 64'(valid0), 64'd1);
        check("s2_frame_a", frame0, FRM_A);
        for (int r = 0; r < 8; r++) drive0(8'h01 << r, 8'h01 << r, 20);
        drive0(8'h00, 8'h00, 10);
        check("s2_overrun", 64'(ovr0), 64'd1);
        check("s2_frame_kept", frame0, FRM_A);
        check("s2_valid_still", 64'(valid0), 64'd1);
        ready0 = 1'b1;
        @(posedge clk);
        #1;
        check("s2_valid_drop", 64'(valid0), 64'd0);

        // two rows selected at once
        err_pulses0 = 0;
        drive0(8'h03, 8'h5A, 10);
        drive0(8'h00, 8'h00, 10);
        check("s3_err_pulses", 64'(err_pulses0), 64'd1);
        check("s3_seen", 64'(dut0.seen_q), 64'd0);
        check("s3_no_frame", 64'(valid0), 64'd0);

        // two-cycle glitch on row 4 is filtered out
        drive0(8'h10, 8'hC3, 2);
        drive0(8'h00, 8'h00, 12);
        check("s4_seen", 64'(dut0.seen_q), 64'd0);

        // partial frame then timeout, then a full all-ones frame
        for (int r = 0; r < 6; r++) drive0(8'h01 << r, 8'h55, 20);
        check("s5_seen_partial", 64'(dut0.seen_q), 64'h3F);
        drive0(8'h00, 8'h00, 120);
        check("s5_unlocked", 64'(locked0), 64'd0);
        check("s5_seen_cleared", 64'(dut0.seen_q), 64'd0);
        check("s5_frame_untouched", frame0, FRM_A);
        check("s5_valid_untouched", 64'(valid0), 64'd0);
        exp_q0.push_back(ONES);
        for (int r = 0; r < 8; r++) drive0(8'h01 << r, 8'hFF, 20);
        drive0(8'h00, 8'h00, 10);
        check("s5_relocked", 64'(locked0), 64'd1);

        // active-low instance with inverted diagonal stimulus
        exp_q1.push_back(DIAG);
        for (int r = 0; r < 8; r++) drive1(~(8'h01 << r), ~(8'h01 << r), 20);
        drive1(8'hFF, 8'hFF, 10);
        check("s6_locked", 64'(locked1), 64'd1);
        check("s6_valid_after_xfer", 64'(valid1), 64'd0);
        ready1 = 1'b0;
        for (int r = 0; r < 8; r++) drive1(~(8'h01 << r), ~(8'h01 << r), 20);
        drive1(8'hFF, 8'hFF, 10);
        check("s6_valid_held", 64'(valid1), 64'd1);
        check("s6_frame_held", frame1, DIAG);

        // reset in the middle of a frame
        for (int r = 0; r < 4; r++) drive1(~(8'h01 << r), 8'h00, 20);
        rows1 = 8'hFF;
        cols1 = 8'hFF;
        rst1_n = 1'b0;
        @(posedge clk);
        #1;
        check("s6_rst_frame", frame1, 64'd0);
        check("s6_rst_valid", 64'(valid1), 64'd0);
        check("s6_rst_locked", 64'(locked1), 64'd0);
        check("s6_rst_overrun", 64'(ovr1), 64'd0);
        check("s6_rst_err", 64'(err1), 64'd0);
        rst1_n = 1'b1;
        for (int r = 4; r < 8; r++) drive1(~(8'h01 << r), 8'h00, 20);
        drive1(8'hFF, 8'hFF, 10);
        check("s6_partial_discarded", 64'(valid1), 64'd0);
        check("s6_partial_unlocked", 64'(locked1), 64'd0);
        check("s6_seen_after_rst", 64'(dut1.seen_q), 64'hF0);

        check("q0_drained", 64'(exp_q0.size()), 64'd0);
        check("q1_drained", 64'(exp_q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
